// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stages of the RV core:
// stage bundle layouts, the NOP bubble word and the occupancy encoding.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_wr;
    } mem_wb_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

    function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_r;

    // Count register: hold at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (inc && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline stage with optional two-entry skid buffer,
// flush for mispredicts and a saturating stall counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int               DATA_W     = 32,
    parameter int               SKID       = 1,
    parameter logic [DATA_W-1:0] RESET_DATA = DATA_W'(NOP_INSTR),
    parameter int               CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_valid_r, main_valid_n;
    logic [DATA_W-1:0] main_data_r,  main_data_n;
    logic              skid_valid_r, skid_valid_n;
    logic [DATA_W-1:0] skid_data_r,  skid_data_n;
    logic              in_ready_s;
    logic              in_fire_s;
    logic              out_fire_s;

    // Ready generation; with the skid buffer it depends only on held state.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else if (SKID != 0) begin
            in_ready_s = !skid_valid_r;
        end else begin
            in_ready_s = !main_valid_r || out_ready;
        end
    end

    assign in_fire_s  = in_valid && in_ready_s;
    assign out_fire_s = main_valid_r && out_ready;

    // Next-state for main and skid entries; flush drops everything incl. this cycle's input.
    always_comb begin
        main_valid_n = main_valid_r;
        main_data_n  = main_data_r;
        skid_valid_n = skid_valid_r;
        skid_data_n  = skid_data_r;
        if (flush) begin
            main_valid_n = 1'b0;
            main_data_n  = RESET_DATA;
            skid_valid_n = 1'b0;
        end else if (SKID != 0) begin
            if (!main_valid_r || out_fire_s) begin
                if (skid_valid_r) begin
                    main_valid_n = 1'b1;
                    main_data_n  = skid_data_r;
                    skid_valid_n = in_fire_s;
                    skid_data_n  = in_fire_s ? in_data : skid_data_r;
                end else if (in_fire_s) begin
                    main_valid_n = 1'b1;
                    main_data_n  = in_data;
                end else begin
                    main_valid_n = 1'b0;
                    main_data_n  = RESET_DATA;
                end
            end else if (in_fire_s) begin
                skid_valid_n = 1'b1;
                skid_data_n  = in_data;
            end else begin
                skid_valid_n = skid_valid_r;
            end
        end else begin
            skid_valid_n = 1'b0;
            if (in_fire_s) begin
                main_valid_n = 1'b1;
                main_data_n  = in_data;
            end else if (out_fire_s) begin
                main_valid_n = 1'b0;
                main_data_n  = RESET_DATA;
            end else begin
                main_valid_n = main_valid_r;
            end
        end
    end

    // Entry registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_r <= 1'b0;
            main_data_r  <= RESET_DATA;
            skid_valid_r <= 1'b0;
            skid_data_r  <= RESET_DATA;
        end else begin
            main_valid_r <= main_valid_n;
            main_data_r  <= main_data_n;
            skid_valid_r <= skid_valid_n;
            skid_data_r  <= skid_data_n;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (main_valid_r && !out_ready),
        .clr (clr_stats),
        .cnt (stall_cnt)
    );

    assign in_ready  = in_ready_s;
    assign out_valid = main_valid_r;
    assign out_data  = main_data_r;
    assign occupancy = occ_count(main_valid_r, skid_valid_r);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: table-driven vectors on the skid variant plus hand
// sequences for stall saturation and the combinational-ready variant.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready, clr_stats;
    logic [31:0] in_data;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_data;
    logic [1:0]  s_occ;
    logic [3:0]  s_stall;

    logic        n_in_ready, n_out_valid;
    logic [31:0] n_out_data;
    logic [1:0]  n_occ;
    logic [15:0] n_stall;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(32), .SKID(1), .RESET_DATA(32'h0000_0013), .CNT_W(4)) u_s (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .occupancy(s_occ), .clr_stats(clr_stats), .stall_cnt(s_stall));

    pipe_stage_skid #(.DATA_W(32), .SKID(0), .RESET_DATA(32'h0000_0013), .CNT_W(16)) u_n (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_data(in_data), .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
        .occupancy(n_occ), .clr_stats(clr_stats), .stall_cnt(n_stall));

    typedef struct {
        logic        rst, fl, iv;
        logic [31:0] id;
        logic        ordy, clr;
        logic        ev;
        logic [31:0] ed;
        logic [1:0]  occ;
        logic        ir;
        logic [3:0]  st;
    } vec_t;

    vec_t tv [0:20];

    function automatic vec_t mk(logic r, logic f, logic iv, logic [31:0] id, logic ordy, logic c,
                                logic ev, logic [31:0] ed, logic [1:0] occ, logic ir, logic [3:0] st);
        vec_t v;
        v.rst = r; v.fl = f; v.iv = iv; v.id = id; v.ordy = ordy; v.clr = c;
        v.ev = ev; v.ed = ed; v.occ = occ; v.ir = ir; v.st = st;
        return v;
    endfunction

    task automatic drive(logic r, logic f, logic iv, logic [31:0] id, logic ordy, logic c);
        rst = r; flush = f; in_valid = iv; in_data = id; out_ready = ordy; clr_stats = c;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        //           rst fl iv id          ordy clr | ev ed            occ        ir st
        tv[0]  = mk(1, 0, 1, 32'hA5, 1, 0,  0, 32'h13, OCC_EMPTY, 0, 4'd0);
        tv[1]  = mk(1, 0, 1, 32'hA5, 1, 0,  0, 32'h13, OCC_EMPTY, 0, 4'd0);
        tv[2]  = mk(0, 0, 1, 32'h01, 1, 0,  0, 32'h13, OCC_EMPTY, 1, 4'd0);
        tv[3]  = mk(0, 0, 1, 32'h02, 1, 0,  1, 32'h01, OCC_ONE,   1, 4'd0);
        tv[4]  = mk(0, 0, 1, 32'h03, 1, 0,  1, 32'h02, OCC_ONE,   1, 4'd0);
        tv[5]  = mk(0, 0, 1, 32'h04, 1, 0,  1, 32'h03, OCC_ONE,   1, 4'd0);
        tv[6]  = mk(0, 0, 0, 32'h00, 1, 0,  1, 32'h04, OCC_ONE,   1, 4'd0);
        tv[7]  = mk(0, 0, 1, 32'h10, 1, 0,  0, 32'h13, OCC_EMPTY, 1, 4'd0);
        tv[8]  = mk(0, 0, 1, 32'h11, 0, 0,  1, 32'h10, OCC_ONE,   1, 4'd0);
        tv[9]  = mk(0, 0, 0, 32'h00, 0, 0,  1, 32'h10, OCC_FULL,  0, 4'd1);
        tv[10] = mk(0, 0, 0, 32'h00, 0, 0,  1, 32'h10, OCC_FULL,  0, 4'd2);
        tv[11] = mk(0, 0, 0, 32'h00, 1, 0,  1, 32'h10, OCC_FULL,  0, 4'd3);
        tv[12] = mk(0, 0, 0, 32'h00, 1, 0,  1, 32'h11, OCC_ONE,   1, 4'd3);
        tv[13] = mk(0, 0, 0, 32'h00, 1, 0,  0, 32'h13, OCC_EMPTY, 1, 4'd3);
        tv[14] = mk(0, 0, 1, 32'h20, 0, 0,  0, 32'h13, OCC_EMPTY, 1, 4'd3);
        tv[15] = mk(0, 0, 1, 32'h21, 0, 0,  1, 32'h20, OCC_ONE,   1, 4'd3);
        tv[16] = mk(0, 1, 1, 32'h55, 0, 0,  1, 32'h20, OCC_FULL,  0, 4'd4);
        tv[17] = mk(0, 0, 0, 32'h00, 1, 0,  0, 32'h13, OCC_EMPTY, 1, 4'd5);
        tv[18] = mk(0, 1, 1, 32'h66, 1, 0,  0, 32'h13, OCC_EMPTY, 1, 4'd5);
        tv[19] = mk(0, 0, 0, 32'h00, 1, 0,  0, 32'h13, OCC_EMPTY, 1, 4'd5);
        tv[20] = mk(0, 0, 1, 32'h30, 0, 0,  0, 32'h13, OCC_EMPTY, 1, 4'd5);

        drive(1, 0, 1, 32'hA5, 1, 0);
        @(posedge clk); #1;

        for (int i = 0; i <= 20; i++) begin
            drive(tv[i].rst, tv[i].fl, tv[i].iv, tv[i].id, tv[i].ordy, tv[i].clr);
            @(negedge clk);
            check($sformatf("v%0d out_valid", i), {31'd0, s_out_valid}, {31'd0, tv[i].ev});
            check($sformatf("v%0d out_data", i), s_out_data, tv[i].ed);
            check($sformatf("v%0d occupancy", i), {30'd0, s_occ}, {30'd0, tv[i].occ});
            check($sformatf("v%0d in_ready", i), {31'd0, s_in_ready}, {31'd0, tv[i].ir});
            check($sformatf("v%0d stall_cnt", i), {28'd0, s_stall}, {28'd0, tv[i].st});
            @(posedge clk); #1;
        end

        // Long stall: counter climbs from 5 and pins at 15.
        for (int k = 0; k < 20; k++) begin
            drive(0, 0, 0, 32'h0, 0, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("sat stall_cnt", {28'd0, s_stall}, 32'd15);
        check("sat out_data held", s_out_data, 32'h30);
        check("sat out_valid", {31'd0, s_out_valid}, 32'd1);
        drive(0, 0, 0, 32'h0, 0, 1);
        @(posedge clk); #1;
        drive(0, 0, 0, 32'h0, 0, 0);
        @(negedge clk);
        check("clr stall_cnt", {28'd0, s_stall}, 32'd0);
        drive(0, 0, 0, 32'h0, 1, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("drain out_valid", {31'd0, s_out_valid}, 32'd0);
        check("drain out_data", s_out_data, 32'h13);

        // Combinational-ready variant.
        drive(1, 0, 0, 32'h0, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 1, 32'h7, 0, 0);
        @(negedge clk);
        check("n empty in_ready", {31'd0, n_in_ready}, 32'd1);
        check("n empty out_valid", {31'd0, n_out_valid}, 32'd0);
        @(posedge clk); #1;
        drive(0, 0, 1, 32'h8, 0, 0);
        @(negedge clk);
        check("n full in_ready", {31'd0, n_in_ready}, 32'd0);
        check("n held data", n_out_data, 32'h7);
        out_ready = 1'b1;
        #1;
        check("n comb in_ready", {31'd0, n_in_ready}, 32'd1);
        @(posedge clk); #1;
        drive(0, 0, 0, 32'h0, 1, 0);
        @(negedge clk);
        check("n out_data", n_out_data, 32'h8);
        check("n out_valid", {31'd0, n_out_valid}, 32'd1);
        check("n occupancy", {30'd0, n_occ}, 32'd1);
        check("n stall_cnt", {16'd0, n_stall}, 32'd0);
        @(posedge clk); #1;
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, (i <= 4), i, 1, 0);
            @(negedge clk);
            if (i == 1) check("n stream idle", n_out_data, 32'h13);
            else check($sformatf("n stream %0d", i - 1), n_out_data, i - 1);
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
